// File: rtl/wb_arbiter_pkg.sv
// Shared types and constants for the writeback arbiter slice.
// Entry layout, source ids and the round-robin successor helper.
package wb_arbiter_pkg;

  localparam int WB_NUM_CKPT = 4;
  localparam int WB_PRD_W    = 7;
  localparam int WB_DATA_W   = 32;

  localparam int WB_SRC_ALU  = 0;
  localparam int WB_SRC_B    = 1;
  localparam int WB_SRC_LSU  = 2;
  localparam int WB_NUM_SRC  = 3;

  typedef struct packed {
    logic [WB_PRD_W-1:0]    prd;
    logic [WB_DATA_W-1:0]   data;
    logic [WB_NUM_CKPT-1:0] br_mask;
  } wb_entry_t;

  typedef enum logic [1:0] {
    SRC_ALU = 2'd0,
    SRC_B   = 2'd1,
    SRC_LSU = 2'd2
  } wb_src_e;

  function automatic wb_src_e wb_src_next(input wb_src_e s);
    unique case (s)
      SRC_ALU: return SRC_B;
      SRC_B:   return SRC_LSU;
      default: return SRC_ALU;
    endcase
  endfunction

endpackage

// File: rtl/wb_skid_fifo.sv
// Per-source result buffer with squash, resolve and hole compaction.
// Optional same-cycle bypass when empty: macro WB_ARB_BYPASS_EN.
module wb_skid_fifo
  import wb_arbiter_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int CKW   = $clog2(WB_NUM_CKPT)
)(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_valid,
  input  wb_entry_t            i_entry,
  output logic                 o_ready,
  input  logic                 i_mispredict,
  input  logic [CKW-1:0]       i_mp_ckpt,
  input  logic                 i_resolve,
  input  logic [CKW-1:0]       i_rs_ckpt,
  input  logic                 i_pop,
  output logic                 o_head_valid,
  output logic [WB_PRD_W-1:0]  o_head_prd,
  output logic [WB_DATA_W-1:0] o_head_data
);

  wb_entry_t              r_mem [DEPTH];
  logic [CW-1:0]          r_count;

  wb_entry_t              w_next [DEPTH];
  logic [CW-1:0]          w_n;
  logic [DEPTH-1:0]       w_keep;
  logic [AW-1:0]          w_head_idx;
  logic [WB_NUM_CKPT-1:0] w_clr;
  logic                   w_any;
  logic                   w_in_live;
  logic                   w_byp;
  logic                   w_push;

  assign o_ready = (r_count < CW'(DEPTH));

  // resolved checkpoint bit to strip from every mask
  always_comb begin
    w_clr = '0;
    if (i_resolve) w_clr[i_rs_ckpt] = 1'b1;
  end

  // live entries after this cycle's squash
  always_comb begin
    for (int i = 0; i < DEPTH; i++)
      w_keep[i] = (CW'(i) < r_count) &&
                  !(i_mispredict && r_mem[i].br_mask[i_mp_ckpt]);
  end

  // oldest surviving entry is the head
  always_comb begin
    w_head_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (w_keep[i]) w_head_idx = AW'(i);
  end

  assign w_any     = |w_keep;
  assign w_in_live = i_valid && o_ready &&
                     (i_entry.prd != '0) &&
                     !(i_mispredict && i_entry.br_mask[i_mp_ckpt]);

`ifdef WB_ARB_BYPASS_EN
  assign w_byp = w_in_live && !w_any;
`else
  assign w_byp = 1'b0;
`endif

  assign o_head_valid = w_any || w_byp;
  assign o_head_prd   = w_any ? r_mem[w_head_idx].prd  : i_entry.prd;
  assign o_head_data  = w_any ? r_mem[w_head_idx].data : i_entry.data;

  // a granted bypass result never lands in the buffer
  assign w_push = w_in_live && !(w_byp && i_pop);

  // compact survivors, drop popped head, append the new result
  always_comb begin
    w_n = '0;
    for (int i = 0; i < DEPTH; i++) w_next[i] = r_mem[i];
    for (int i = 0; i < DEPTH; i++) begin
      if (w_keep[i] &&
          !(i_pop && w_any && (AW'(i) == w_head_idx))) begin
        w_next[w_n[AW-1:0]] = '{
          prd:     r_mem[i].prd,
          data:    r_mem[i].data,
          br_mask: r_mem[i].br_mask & ~w_clr
        };
        w_n = w_n + 1'b1;
      end
    end
    if (w_push && (w_n < CW'(DEPTH))) begin
      w_next[w_n[AW-1:0]] = '{
        prd:     i_entry.prd,
        data:    i_entry.data,
        br_mask: i_entry.br_mask & ~w_clr
      };
      w_n = w_n + 1'b1;
    end
  end

  // buffer state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      r_count <= w_n;
      r_mem   <= w_next;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: three FU buffers drained round-robin onto 2 ports.
// Optional same-cycle bypass: define WB_ARB_BYPASS_EN.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter  int DEPTH    = 2,
  parameter  int NUM_CKPT = WB_NUM_CKPT,
  parameter  int WB_PORTS = 2,
  localparam int CKW      = $clog2(NUM_CKPT)
)(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      alu_valid,
  input  logic                      b_valid,
  input  logic                      lsu_valid,
  output logic                      alu_ready,
  output logic                      b_ready,
  output logic                      lsu_ready,
  input  logic [6:0]                alu_prd,
  input  logic [6:0]                b_prd,
  input  logic [6:0]                lsu_prd,
  input  logic [31:0]               alu_data,
  input  logic [31:0]               b_data,
  input  logic [31:0]               lsu_data,
  input  logic [NUM_CKPT-1:0]       alu_br_mask,
  input  logic [NUM_CKPT-1:0]       b_br_mask,
  input  logic [NUM_CKPT-1:0]       lsu_br_mask,
  input  logic                      mispredict,
  input  logic [CKW-1:0]            mispredict_ckpt,
  input  logic                      resolve_valid,
  input  logic [CKW-1:0]            resolve_ckpt,
  output logic [WB_PORTS-1:0]       wb_valid,
  output logic [WB_PORTS-1:0][6:0]  wb_prd,
  output logic [WB_PORTS-1:0][31:0] wb_data
);

  wb_entry_t             w_in    [WB_NUM_SRC];
  logic                  w_vin   [WB_NUM_SRC];
  logic                  w_rdy   [WB_NUM_SRC];
  logic [WB_PRD_W-1:0]   w_hprd  [WB_NUM_SRC];
  logic [WB_DATA_W-1:0]  w_hdata [WB_NUM_SRC];
  logic [WB_NUM_SRC-1:0] w_req;
  logic [WB_NUM_SRC-1:0] w_pop;

  wb_src_e               r_rr;
  wb_src_e               w_rr_next;
  wb_src_e               w_scan;
  wb_src_e               w_gsrc [2];
  logic [1:0]            w_gv;

  assign w_in[WB_SRC_ALU] = '{alu_prd, alu_data, alu_br_mask};
  assign w_in[WB_SRC_B]   = '{b_prd,   b_data,   b_br_mask};
  assign w_in[WB_SRC_LSU] = '{lsu_prd, lsu_data, lsu_br_mask};

  assign w_vin[WB_SRC_ALU] = alu_valid;
  assign w_vin[WB_SRC_B]   = b_valid;
  assign w_vin[WB_SRC_LSU] = lsu_valid;

  assign alu_ready = w_rdy[WB_SRC_ALU];
  assign b_ready   = w_rdy[WB_SRC_B];
  assign lsu_ready = w_rdy[WB_SRC_LSU];

  for (genvar g = 0; g < WB_NUM_SRC; g++) begin : g_src
    wb_skid_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk          (clk),
      .reset        (reset),
      .i_valid      (w_vin[g]),
      .i_entry      (w_in[g]),
      .o_ready      (w_rdy[g]),
      .i_mispredict (mispredict),
      .i_mp_ckpt    (mispredict_ckpt),
      .i_resolve    (resolve_valid),
      .i_rs_ckpt    (resolve_ckpt),
      .i_pop        (w_pop[g]),
      .o_head_valid (w_req[g]),
      .o_head_prd   (w_hprd[g]),
      .o_head_data  (w_hdata[g])
    );
  end

  // scan from rr_ptr, grant first two live heads
  always_comb begin
    w_gv      = '0;
    w_gsrc[0] = SRC_ALU;
    w_gsrc[1] = SRC_ALU;
    w_pop     = '0;
    w_rr_next = r_rr;
    w_scan    = r_rr;
    for (int k = 0; k < WB_NUM_SRC; k++) begin
      if (w_req[w_scan] && !w_gv[1]) begin
        if (!w_gv[0]) begin
          w_gv[0]   = 1'b1;
          w_gsrc[0] = w_scan;
        end else begin
          w_gv[1]   = 1'b1;
          w_gsrc[1] = w_scan;
        end
        w_pop[w_scan] = 1'b1;
        w_rr_next     = wb_src_next(w_scan);
      end
      w_scan = wb_src_next(w_scan);
    end
  end

  // pointer and registered write ports; idle ports hold prd/data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr     <= SRC_ALU;
      wb_valid <= '0;
      wb_prd   <= '0;
      wb_data  <= '0;
    end else begin
      r_rr <= w_rr_next;
      for (int p = 0; p < 2; p++) begin
        wb_valid[p] <= w_gv[p];
        if (w_gv[p]) begin
          wb_prd[p]  <= w_hprd[w_gsrc[p]];
          wb_data[p] <= w_hdata[w_gsrc[p]];
        end
      end
    end
  end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter between the three functional units (ALU, branch unit, LSU) and the physical register file write ports. Each FU pushes results into a small per-source buffer. A round-robin arbiter drains up to two results per cycle onto registered PRF write ports. Results on a mispredicted path are squashed using per-entry branch masks, and results whose branch resolves correctly have that mask bit cleared.

## Interface
Parameters:
- DEPTH, 2, entries per source buffer (power of 2, ≥2)
- NUM_CKPT, 4, checkpoint count and branch-mask width
- WB_PORTS, 2, PRF write ports driven (fixed 2 in this revision)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high; clears all state
- alu_valid / b_valid / lsu_valid  in  1  result offered by the FU
- alu_ready / b_ready / lsu_ready  out  1  buffer can accept; equals count<DEPTH
- alu_prd / b_prd / lsu_prd  in  7  destination physical register
- alu_data / b_data / lsu_data  in  32  result value
- alu_br_mask / b_br_mask / lsu_br_mask  in  NUM_CKPT  checkpoints the result depends on
- mispredict  in  1  squash request
- mispredict_ckpt  in  $clog2(NUM_CKPT)  mispredicted checkpoint index
- resolve_valid  in  1  branch resolved correctly
- resolve_ckpt  in  $clog2(NUM_CKPT)  resolved checkpoint index
- wb_valid  out  WB_PORTS  per-port write enable (registered)
- wb_prd  out  WB_PORTS×7  per-port target register (registered)
- wb_data  out  WB_PORTS×32  per-port data (registered)

## Operation
- Accept: handshake when valid && ready. If prd==0, the result is accepted and discarded.
- Squash: an entry is removed if mispredict && br_mask[mispredict_ckpt]. This applies to buffered entries and to the incoming result in the same cycle; the incoming result is accepted (ready is unchanged) and then dropped. Squash is applied before arbitration, so a squashed entry is never granted.
- Resolve: on resolve_valid, clear bit resolve_ckpt in all buffered masks and in the incoming mask.
- Mispredict and resolve on the same index in the same cycle: mispredict wins.
- Squashed holes are compacted so the buffers stay FIFO. Order within a source is preserved.
- Arbitration:
  - rr_ptr ∈ {ALU=0, B=1, LSU=2}, reset value 0.
  - Scan the three sources starting at rr_ptr and grant up to two non-empty heads.
  - The first grant goes to port 0, the second to port 1.
  - rr_ptr advances to (last granted source + 1) mod 3. It is unchanged if nothing is granted.
- Outputs: for each granted head, wb_valid=1 with its prd/data. Ungranted ports drive wb_valid=0, and prd/data hold their previous values.
- Reset values: wb_valid=0, wb_prd=0, wb_data=0, all counts 0, all *_ready=1 once reset deasserts.

## Timing
- Latency without bypass: a result accepted in cycle t is at the head in t+1 and on wb_* in t+2, assuming it wins arbitration.
- *_ready is a function of the registered count only; there is no combinational path from valid or from grant.
- A full buffer that pops in the same cycle still shows ready=0 that cycle (no pop-through).
- Squash and resolve take effect in the cycle they are asserted, with no delay.
- Reset asserted mid-operation: all buffers empty and wb_valid=0 immediately (asynchronously). In-flight results are lost.
- Up to three results per cycle may be accepted while only two drain per cycle. Sustained three-source traffic fills the buffers and back-pressures via ready.

## Configuration
- WB_ARB_BYPASS_EN defined:
  - When a source buffer is empty, its incoming non-squashed, non-zero-prd result competes in arbitration in the same cycle. It appears on wb_* in t+1.
  - If it is granted, it is not written into the buffer.
  - *_ready is unchanged (still count-based).
- WB_ARB_BYPASS_EN undefined: every result passes through the buffer, and minimum latency is 2 cycles.

## Structure
- types_pkg additions:
  - wb_entry_t struct {prd[6:0], data[31:0], br_mask[NUM_CKPT-1:0]}.
  - Constants WB_SRC_ALU=0, WB_SRC_B=1, WB_SRC_LSU=2, WB_NUM_SRC=3.
- Sub-module wb_skid_fifo, instantiated three times. It provides push, pop, squash/resolve mask update, compaction, and count.
- wb_arbiter contains the round-robin grant logic and the output registers.

## Test plan
- Reset then idle: wb_valid=2'b00, all ready=1. Assert reset mid-stream with 2 entries buffered: buffers empty, wb_valid=0 in the same cycle.
- Single ALU push of prd=5, data=0xDEADBEEF at cycle t: wb port 0 shows valid with 5/0xDEADBEEF at t+2, or at t+1 with WB_ARB_BYPASS_EN.
- All three FUs push every cycle:
  - Exactly 2 writes per cycle, with grants rotating ALU+B, LSU+ALU, B+LSU.
  - Buffers fill and ready drops after DEPTH-induced backlog.
  - No result is lost or reordered per source.
- Squash: LSU buffer holds masks 4'b0010 and 4'b0000; mispredict with ckpt=1. Only the 4'b0000 entry is written. An incoming result with mask 4'b0010 in that cycle is accepted and never appears.
- Resolve then mispredict: entry with mask 4'b0100, resolve ckpt=2, then mispredict ckpt=2 one cycle later: the entry is still written. Resolve and mispredict on the same index in the same cycle: the entry is squashed.
- A push with prd=0 is accepted and never appears on wb_valid.
